// File: rtl/mtm_alu_rsp_decoder.sv
// Serial response decoder for the mtm ALU: frames the sout line into DATA/CTL
// bytes, assembles the 32-bit result and checks CRC3 / error-frame parity.
module mtm_alu_rsp_decoder #(
  parameter int CHECK_CRC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sout,
  output logic        rsp_valid,
  output logic [31:0] rsp_c,
  output logic [3:0]  rsp_flags,
  output logic        rsp_crc_ok,
  output logic        rsp_err,
  output logic [2:0]  rsp_err_flags,
  output logic        rsp_par_ok,
  output logic        proto_err
);

  typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, EMIT} state_t;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_is_ctl;
  logic [2:0]  r_data_cnt;
  logic [31:0] r_acc;

  logic [2:0]  w_crc;
  logic        w_crc_match;
  logic        w_par_ok;

  // CRC3, polynomial x^3+x+1, init 0, data consumed MSB first
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  assign w_crc       = crc3({r_acc, 1'b0, r_shift[6:3]});
  assign w_crc_match = (w_crc == r_shift[2:0]);
  assign w_par_ok    = (r_shift[0] == ~^r_shift[7:1]) && (r_shift[6:4] == r_shift[3:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_is_ctl      <= 1'b0;
      r_data_cnt    <= '0;
      r_acc         <= '0;
      rsp_valid     <= 1'b0;
      proto_err     <= 1'b0;
      rsp_c         <= '0;
      rsp_flags     <= '0;
      rsp_crc_ok    <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_err_flags <= '0;
      rsp_par_ok    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      proto_err <= 1'b0;
      case (r_state)
        // EMIT also watches for a start bit so a frame may follow with no gap
        IDLE, EMIT: r_state <= sout ? IDLE : TYPE;
        TYPE: begin
          r_is_ctl  <= sout;
          r_bit_cnt <= '0;
          r_state   <= PAYLOAD;
        end
        PAYLOAD: begin
          r_shift   <= {r_shift[6:0], sout};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= STOP;
        end
        STOP: begin
          r_state <= IDLE;
          if (!sout) begin
            proto_err  <= 1'b1;
            r_data_cnt <= '0;
          end else if (!r_is_ctl) begin
            if (r_data_cnt == 3'd4) begin
              proto_err  <= 1'b1;
              r_data_cnt <= '0;
            end else begin
              r_acc      <= {r_acc[23:0], r_shift};
              r_data_cnt <= r_data_cnt + 3'd1;
            end
          end else begin
            r_data_cnt <= '0;
            r_state    <= EMIT;
            if (r_shift[7]) begin
              rsp_valid     <= 1'b1;
              rsp_err       <= 1'b1;
              rsp_c         <= '0;
              rsp_flags     <= '0;
              rsp_crc_ok    <= 1'b0;
              rsp_err_flags <= r_shift[6:4];
              rsp_par_ok    <= w_par_ok;
            end else if (r_data_cnt == 3'd4) begin
              rsp_valid     <= 1'b1;
              rsp_err       <= 1'b0;
              rsp_c         <= r_acc;
              rsp_flags     <= r_shift[6:3];
              rsp_crc_ok    <= (CHECK_CRC == 0) || w_crc_match;
              rsp_err_flags <= '0;
              rsp_par_ok    <= 1'b0;
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_rsp_decoder.sv
// Directed bench for mtm_alu_rsp_decoder: framed stimulus on sout, hand-computed
// expectations, pulse counters sampled on the falling edge.
module tb_mtm_alu_rsp_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sout = 1'b1;

  logic        rsp_valid, rsp_crc_ok, rsp_err, rsp_par_ok, proto_err;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic [2:0]  rsp_err_flags;

  logic        nc_valid, nc_crc_ok, nc_err, nc_par_ok, nc_perr;
  logic [31:0] nc_c;
  logic [3:0]  nc_flags;
  logic [2:0]  nc_err_flags;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_perr = 0;
  int v0, p0;

  always #5 clk = ~clk;

  mtm_alu_rsp_decoder #(.CHECK_CRC(1)) dut (
    .clk(clk), .rst(rst), .sout(sout),
    .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
    .rsp_crc_ok(rsp_crc_ok), .rsp_err(rsp_err), .rsp_err_flags(rsp_err_flags),
    .rsp_par_ok(rsp_par_ok), .proto_err(proto_err)
  );

  mtm_alu_rsp_decoder #(.CHECK_CRC(0)) u_nocrc (
    .clk(clk), .rst(rst), .sout(sout),
    .rsp_valid(nc_valid), .rsp_c(nc_c), .rsp_flags(nc_flags),
    .rsp_crc_ok(nc_crc_ok), .rsp_err(nc_err), .rsp_err_flags(nc_err_flags),
    .rsp_par_ok(nc_par_ok), .proto_err(nc_perr)
  );

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) n_valid++;
    if (proto_err === 1'b1) n_perr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sout = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic ctl, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(ctl);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  task automatic send_pkt(input logic [31:0] c, input logic [7:0] ctl);
    send_frame(1'b0, c[31:24], 1'b1);
    send_frame(1'b0, c[23:16], 1'b1);
    send_frame(1'b0, c[15:8],  1'b1);
    send_frame(1'b0, c[7:0],   1'b1);
    send_frame(1'b1, ctl,      1'b1);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    sout = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_c", rsp_c, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_crc_ok", rsp_crc_ok, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_err_flags", rsp_err_flags, 0);
    chk("rst_par_ok", rsp_par_ok, 0);
    rst = 1'b0;
    send_bit(1'b1);

    // zero result, flags 0010, good CRC 110
    v0 = n_valid;
    send_pkt(32'h0, 8'h16);
    chk("p16_valid", rsp_valid, 1);
    chk("p16_c", rsp_c, 32'h0);
    chk("p16_flags", rsp_flags, 4'b0010);
    chk("p16_crc_ok", rsp_crc_ok, 1);
    chk("p16_err", rsp_err, 0);
    send_bit(1'b1);
    chk("p16_pulse_end", rsp_valid, 0);
    chk("p16_hold_flags", rsp_flags, 4'b0010);
    chk("p16_pulses", n_valid - v0, 1);

    // wrong CRC: checked instance flags it, unchecked instance forces ok
    send_pkt(32'h0, 8'h17);
    chk("p17_valid", rsp_valid, 1);
    chk("p17_crc_ok", rsp_crc_ok, 0);
    chk("p17_nocrc_ok", nc_crc_ok, 1);
    send_bit(1'b1);

    // C=1, flags 0 -> CRC 010
    send_pkt(32'h0000_0001, 8'h02);
    chk("c1_c", rsp_c, 32'h1);
    chk("c1_crc_ok", rsp_crc_ok, 1);
    send_bit(1'b1);

    // C=8000_0000, flags 1000 -> CRC 011
    send_pkt(32'h8000_0000, 8'h43);
    chk("c80_c", rsp_c, 32'h8000_0000);
    chk("c80_flags", rsp_flags, 4'b1000);
    chk("c80_crc_ok", rsp_crc_ok, 1);
    send_bit(1'b1);

    // error frames at data count 0
    send_frame(1'b1, 8'h92, 1'b1);
    chk("e92_valid", rsp_valid, 1);
    chk("e92_err", rsp_err, 1);
    chk("e92_err_flags", rsp_err_flags, 3'b001);
    chk("e92_par_ok", rsp_par_ok, 1);
    chk("e92_flags", rsp_flags, 0);
    chk("e92_crc_ok", rsp_crc_ok, 0);
    send_bit(1'b1);
    send_frame(1'b1, 8'h93, 1'b1);
    chk("e93_par_ok", rsp_par_ok, 0);
    send_bit(1'b1);
    send_frame(1'b1, 8'hC1, 1'b1);
    chk("eC1_err_flags", rsp_err_flags, 3'b100);
    chk("eC1_par_ok", rsp_par_ok, 0);
    send_bit(1'b1);
    // error frame after two DATA frames is still legal
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b1, 8'hEC, 1'b1);
    chk("eEC_valid", rsp_valid, 1);
    chk("eEC_err_flags", rsp_err_flags, 3'b110);
    chk("eEC_par_ok", rsp_par_ok, 1);
    send_bit(1'b1);

    // result control with only two DATA frames
    v0 = n_valid;
    p0 = n_perr;
    send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b1, 8'h16, 1'b1);
    chk("short_perr", proto_err, 1);
    chk("short_valid", rsp_valid, 0);
    send_bit(1'b1);
    chk("short_perr_end", proto_err, 0);
    send_pkt(32'h1234_5678, 8'h16);
    chk("after_short_valid", rsp_valid, 1);
    chk("after_short_c", rsp_c, 32'h1234_5678);
    chk("after_short_err", rsp_err, 0);
    send_bit(1'b1);
    chk("short_valid_pulses", n_valid - v0, 1);
    chk("short_perr_pulses", n_perr - p0, 1);

    // framing error, then back-to-back frames with no idle gap
    send_frame(1'b0, 8'h55, 1'b0);
    chk("frm_perr", proto_err, 1);
    chk("frm_valid", rsp_valid, 0);
    send_pkt(32'hDEAD_BEEF, 8'h00);
    chk("b2b_valid", rsp_valid, 1);
    chk("b2b_c", rsp_c, 32'hDEAD_BEEF);
    send_bit(1'b1);

    // fifth DATA frame, then the cleared counter rejects a result control
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b0, 8'h00, 1'b1);
    chk("data5_perr", proto_err, 1);
    send_frame(1'b1, 8'h16, 1'b1);
    chk("data5_ctl_perr", proto_err, 1);
    chk("data5_ctl_valid", rsp_valid, 0);
    send_bit(1'b1);
    send_pkt(32'h0, 8'h16);
    chk("data5_recover_crc", rsp_crc_ok, 1);
    chk("data5_recover_c", rsp_c, 32'h0);
    send_bit(1'b1);

    // reset mid-packet and mid-frame discards partial data
    v0 = n_valid;
    p0 = n_perr;
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'hBB, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    sout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_c", rsp_c, 0);
    rst = 1'b0;
    send_bit(1'b1);
    send_pkt(32'h0000_0001, 8'h02);
    chk("post_rst_c", rsp_c, 32'h1);
    chk("post_rst_crc_ok", rsp_crc_ok, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("post_rst_valid_pulses", n_valid - v0, 1);
    chk("post_rst_perr_pulses", n_perr - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mtm_alu_rsp_decoder.md
MTM_ALU_RSP_DECODER -- requirements
Module: mtm_alu_rsp_decoder

Interface
REQ-001 SHALL have parameter CHECK_CRC, default 1; when 1, the CRC3 of each result frame is checked; when 0, rsp_crc_ok is forced to 1.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port sout, input, 1, the ALU serial response line; idle high; one bit per clk.
REQ-005 SHALL have port rsp_valid, output, 1, a one-cycle pulse marking a completed response.
REQ-006 SHALL have port rsp_c, output, 32, the result C; MSB byte is received first.
REQ-007 SHALL have port rsp_flags, output, 4, {Carry, Overflow, Zero, Negative}.
REQ-008 SHALL have port rsp_crc_ok, output, 1, the received CRC3 matches the computed CRC3.
REQ-009 SHALL have port rsp_err, output, 1, the response was an error frame.
REQ-010 SHALL have port rsp_err_flags, output, 3, {ERR_DATA, ERR_CRC, ERR_OP}.
REQ-011 SHALL have port rsp_par_ok, output, 1, error-frame parity correct and both flag copies equal.
REQ-012 SHALL have port proto_err, output, 1, a one-cycle pulse on a framing or sequence violation.

Function
REQ-013 SHALL decode 11-bit frames: start 0, type bit (0=DATA, 1=CTL), 8 payload bits MSB first, stop 1.
REQ-014 SHALL use FSM states IDLE, TYPE, PAYLOAD (8-bit counter), STOP and EMIT.
- IDLE->TYPE on sout=0.
- TYPE->PAYLOAD unconditionally.
- PAYLOAD->STOP after 8 bits.
- STOP->EMIT or IDLE.
- EMIT->IDLE after one cycle.
REQ-015 SHALL shift each DATA payload into a 32-bit accumulator and increment a 3-bit data counter (0..4).
REQ-016 SHALL treat a CTL payload with bit7=0 as a result control: {0, flags[3:0], crc[2:0]}; it is legal only when the data counter is 4.
REQ-017 SHALL treat a CTL payload with bit7=1 as an error control: {1, ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP, parity}; it is legal at any data count.
REQ-018 SHALL compute the CRC3 over the 37 bits {C, 1'b0, flags}, MSB first, with polynomial x^3+x+1 and init 3'b000.
REQ-019 SHALL define parity as the even parity of payload bits [7:1].
REQ-020 SHALL, on a legal control frame, pulse rsp_valid in EMIT, exactly 1 clk after the stop bit is sampled.
REQ-021 SHALL drive all rsp_* outputs during EMIT and hold them until the next rsp_valid.
REQ-022 SHALL set rsp_flags=0 and rsp_crc_ok=0 for error responses; rsp_err_flags takes the first copy of the flags.
REQ-023 SHALL pulse proto_err 1 clk after the stop bit, with no rsp_valid and the data counter cleared, on any of:
- stop bit sampled 0;
- a 5th DATA frame;
- a result CTL frame with data count !=4.
REQ-024 SHALL clear the data counter after every control frame, legal or not.
REQ-025 SHALL go directly STOP->IDLE after a framing error, so that a 0 on the next cycle starts a new frame.
REQ-026 SHALL NOT treat a 0 during TYPE, PAYLOAD or STOP as a start bit; no re-synchronisation occurs mid-frame.
REQ-027 SHALL support back-to-back frames: a start bit on the cycle after STOP (or after EMIT) is accepted.

Reset
REQ-028 SHALL, while rst=1 at a clk edge, enter IDLE, clear the counters and accumulator, and drive:
- rsp_valid=0, proto_err=0;
- rsp_c=0, rsp_flags=0;
- rsp_crc_ok=0, rsp_err=0;
- rsp_err_flags=0, rsp_par_ok=0.
REQ-029 SHALL, on reset mid-frame or mid-packet, discard the partial data and produce no rsp_valid or proto_err for it.

Verification
REQ-030 Four DATA 8'h00 frames, then CTL 8'h16 -> rsp_valid one cycle after the stop bit, with rsp_c=0, rsp_flags=4'b0010, rsp_crc_ok=1, rsp_err=0.
REQ-031 The same sequence with CTL 8'h17 -> rsp_valid, rsp_crc_ok=0; with CHECK_CRC=0 -> rsp_crc_ok=1.
REQ-032 A single CTL 8'h92 -> rsp_valid, rsp_err=1, rsp_err_flags=3'b001, rsp_par_ok=1; CTL 8'h93 -> rsp_par_ok=0.
REQ-033 Two DATA frames then CTL 8'h16 -> proto_err pulse, no rsp_valid; a following legal 5-frame packet decodes correctly.
REQ-034 A DATA frame with stop bit 0 -> proto_err; then back-to-back legal frames with no idle gap -> correct rsp_c.
REQ-035 rst=1 after two DATA frames, then a full legal packet -> exactly one rsp_valid, carrying only the post-reset data.
